icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
// - Direct-mapped, one-word-per-line instruction cache between the IF stage and the memory controller (mct).
// - Instruction-fetch traffic is served from local storage on a hit, which frees the mct byte port for MM loads and stores.
// - On a miss, a single aligned 32-bit word is fetched through the mct fetch port.
// - Supports redirect cancellation and full invalidation (flush).
// PARAMETERS
// LINES   128  number of cache lines; power of 2, >= 2
// IDX_W   7    log2(LINES); index = if_a[IDX_W+1:2], tag = if_a[31:IDX_W+2]
// PORTS
// clk      in   1   clock, all state updates on rising edge
// rst      in   1   asynchronous reset, active-low
// if_req   in   1   IF requests instruction at if_a; held until if_ok or cancel
// if_a     in   32  fetch PC; bits [1:0] required 00, ignored
// cancel   in   1   abandon current request (branch redirect from EX)
// flush    in   1   invalidate all lines (one-cycle pulse)
// if_ok    out  1   one-cycle pulse: if_n valid for the accepted request
// if_n     out  32  instruction word
// mem_req  out  1   fetch request to mct, held until mem_ok
// mem_a    out  32  word-aligned fetch address to mct
// mem_ok   in   1   one-cycle pulse from mct: mem_n valid
// mem_n    in   32  fetched word (little-endian, assembled by mct)
// BEHAVIOUR
// - Storage: valid[LINES], tag[LINES] (32-IDX_W-2 bits), data[LINES] (32 bits); combinational read, write on clk.
// - Reset (rst=0, async): state=IDLE, all valid=0, if_ok=0, if_n=0, mem_req=0, mem_a=0, drop=0.
//   - Tag and data arrays are not reset.
//   - Reset mid-miss drops mem_req immediately.
// - FSM states:
//   - IDLE:
//     - if_req & ~cancel & hit -> RESP: load if_n=data[idx], set if_ok=1.
//     - if_req & ~cancel & miss -> MISS: set mem_req=1, latch mem_a={if_a[31:2],2'b00}, latch idx/tag.
//     - cancel or ~if_req -> stay IDLE.
//   - MISS:
//     - mem_req held at 1 with mem_a stable until mem_ok.
//     - On mem_ok: write data/tag, set valid=1 (unless flush the same cycle), mem_req=0.
//       - If drop=0 -> RESP with if_n=mem_n, if_ok=1.
//       - If drop=1 -> IDLE, clear drop.
//     - cancel in MISS sets drop=1; the mct transfer cannot abort, so the line is still filled.
//   - RESP: if_ok=1 for exactly this cycle; if_req ignored; -> IDLE.
//     - cancel in RESP does not suppress if_ok; IF discards it.
// - Latency: hit = if_ok 1 cycle after request sampled.
//   - Miss = if_ok 1 cycle after mem_ok.
//   - Max throughput 1 instruction per 2 cycles.
// - hit = valid[idx] & (tag[idx] == if_a[31:IDX_W+2]); evaluated only in IDLE.
// - Flush:
//   - Clears all valid bits in the cycle it is sampled, in any state.
//   - Does not change state; an in-flight miss completes but the filled line stays invalid if flush coincides with mem_ok.
//   - Flush in IDLE together with if_req: lookup sees the pre-flush valid bits (hit still served); the next request misses.
// - if_n holds its last value between if_ok pulses.
// - mem_req never asserted outside MISS; at most one outstanding fetch.
// TESTING
// - Cold miss: reset, if_req a=0x00000004 -> mem_req=1, mem_a=0x00000004 next cycle; mem_ok, mem_n=0x00500093 after 4 cycles -> if_ok=1, if_n=0x00500093 one cycle later.
// - Hit: request 0x00000004 again -> if_ok=1, if_n=0x00500093 one cycle after request; mem_req stays 0.
// - Conflict (LINES=128): fill 0x004, then 0x204 (same index 1) -> miss; re-request 0x004 -> miss again, mem_a=0x004.
// - Cancel: request 0x100 (miss), cancel 2 cycles later, mem_ok with 0xDEADBEEF -> no if_ok, state IDLE; re-request 0x100 -> hit, if_n=0xDEADBEEF.
// - Flush: after filling 0x004, pulse flush -> 0x004 misses; flush on same cycle as mem_ok for 0x008 -> if_ok delivered, next 0x008 request misses.
// - Reset mid-miss: rst=0 while mem_req=1 -> mem_req=0 asynchronously; after release, request 0x004 -> miss.

Source files
------------

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped, one-word-per-line instruction cache between IF and mct
//
// Purpose: serves instruction fetches from local storage on a hit; on a miss
// fetches one aligned 32-bit word through the mct fetch port and fills the line.
// Supports redirect cancellation (cancel) and full invalidation (flush).
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      asynchronous reset, active-low
//   i_if_req   IF fetch request, held until o_if_ok or i_cancel
//   i_if_a     fetch PC (bits [1:0] ignored)
//   i_cancel   abandon current request (branch redirect)
//   i_flush    invalidate all lines (one-cycle pulse)
//   o_if_ok    one-cycle pulse, o_if_n valid
//   o_if_n     instruction word, holds between pulses
//   o_mem_req  fetch request to mct, held until i_mem_ok
//   o_mem_a    word-aligned fetch address to mct
//   i_mem_ok   one-cycle pulse from mct, i_mem_n valid
//   i_mem_n    fetched word
module icache #(
    parameter int LINES = 128,
    parameter int IDX_W = 7
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_a,
    input  logic        i_cancel,
    input  logic        i_flush,
    output logic        o_if_ok,
    output logic [31:0] o_if_n,
    output logic        o_mem_req,
    output logic [31:0] o_mem_a,
    input  logic        i_mem_ok,
    input  logic [31:0] i_mem_n
);

    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MISS = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag_mem  [LINES];
    logic [31:0]      r_data_mem [LINES];

    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             r_drop;
    logic             r_if_ok;
    logic [31:0]      r_if_n;
    logic             r_mem_req;
    logic [31:0]      r_mem_a;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_lookup;
    logic             w_fill;
    logic             w_drop_now;
    logic             w_unused;

    assign w_idx    = i_if_a[IDX_W+1:2];
    assign w_tag    = i_if_a[31:IDX_W+2];
    assign w_unused = ^i_if_a[1:0];

    // Lookup reads the valid bits as registered, so a flush sampled in the
    // same cycle still lets this lookup hit; the clear applies afterwards.
    assign w_hit    = r_valid[w_idx] & (r_tag_mem[w_idx] == w_tag);
    assign w_lookup = (r_state == S_IDLE) & i_if_req & ~i_cancel;
    assign w_fill   = (r_state == S_MISS) & i_mem_ok;

    // A cancel arriving in the same cycle as mem_ok also discards the word.
    assign w_drop_now = r_drop | i_cancel;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_lookup) begin
                    w_next = w_hit ? S_RESP : S_MISS;
                end
            end
            S_MISS: begin
                if (i_mem_ok) begin
                    w_next = w_drop_now ? S_IDLE : S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_if_ok   <= 1'b0;
            r_if_n    <= 32'd0;
            r_mem_req <= 1'b0;
            r_mem_a   <= 32'd0;
            r_idx     <= '0;
            r_tag     <= '0;
            r_drop    <= 1'b0;
            r_valid   <= '0;
        end else begin
            r_if_ok   <= (w_next == S_RESP);
            r_mem_req <= (w_next == S_MISS);

            if (w_lookup & w_hit) begin
                r_if_n <= r_data_mem[w_idx];
            end else if (w_fill & ~w_drop_now) begin
                r_if_n <= i_mem_n;
            end

            if (w_lookup & ~w_hit) begin
                r_mem_a <= {i_if_a[31:2], 2'b00};
                r_idx   <= w_idx;
                r_tag   <= w_tag;
            end

            // The mct transfer cannot be aborted, so a cancel only marks the
            // in-flight word to be discarded when it arrives.
            if (w_fill) begin
                r_drop <= 1'b0;
            end else if ((r_state == S_MISS) & i_cancel) begin
                r_drop <= 1'b1;
            end

            if (i_flush) begin
                r_valid <= '0;
            end else if (w_fill) begin
                r_valid[r_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge i_clk) begin
        if (w_fill) begin
            r_tag_mem[r_idx]  <= r_tag;
            r_data_mem[r_idx] <= i_mem_n;
        end
    end

    assign o_if_ok   = r_if_ok;
    assign o_if_n    = r_if_n;
    assign o_mem_req = r_mem_req;
    assign o_mem_a   = r_mem_a;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache
module tb_icache;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_a = 32'd0;
    logic        i_cancel = 1'b0;
    logic        i_flush = 1'b0;
    logic        o_if_ok;
    logic [31:0] o_if_n;
    logic        o_mem_req;
    logic [31:0] o_mem_a;
    logic        i_mem_ok = 1'b0;
    logic [31:0] i_mem_n = 32'd0;

    int n_cmp = 0;
    int n_err = 0;

    icache #(.LINES(128), .IDX_W(7)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_if_req  (i_if_req),
        .i_if_a    (i_if_a),
        .i_cancel  (i_cancel),
        .i_flush   (i_flush),
        .o_if_ok   (o_if_ok),
        .o_if_n    (o_if_n),
        .o_mem_req (o_mem_req),
        .o_mem_a   (o_mem_a),
        .i_mem_ok  (i_mem_ok),
        .i_mem_n   (i_mem_n)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Request a as a hit (expect word one cycle later) or as a miss (expect
    // mem_req, wait lat cycles, return word via mct, expect if_ok next cycle).
    task automatic fetch(input string tag, input logic [31:0] a, input bit exp_hit,
                         input logic [31:0] word, input int lat);
        i_if_req = 1'b1;
        i_if_a   = a;
        tick();
        if (exp_hit) begin
            check_eq({tag, "_hit_ok"}, o_if_ok, 1);
            check_eq({tag, "_hit_n"}, o_if_n, word);
            check_eq({tag, "_hit_noreq"}, o_mem_req, 0);
        end else begin
            check_eq({tag, "_miss_req"}, o_mem_req, 1);
            check_eq({tag, "_miss_a"}, o_mem_a, {a[31:2], 2'b00});
            check_eq({tag, "_miss_nook"}, o_if_ok, 0);
            repeat (lat) tick();
            check_eq({tag, "_miss_hold"}, o_mem_req, 1);
            i_mem_ok = 1'b1;
            i_mem_n  = word;
            tick();
            i_mem_ok = 1'b0;
            check_eq({tag, "_fill_ok"}, o_if_ok, 1);
            check_eq({tag, "_fill_n"}, o_if_n, word);
            check_eq({tag, "_fill_noreq"}, o_mem_req, 0);
        end
        i_if_req = 1'b0;
        tick();
        check_eq({tag, "_pulse_end"}, o_if_ok, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge i_clk);
        #3;
        check_eq("rst_if_ok", o_if_ok, 0);
        check_eq("rst_if_n", o_if_n, 0);
        check_eq("rst_mem_req", o_mem_req, 0);
        check_eq("rst_mem_a", o_mem_a, 0);
        i_rst = 1'b1;
        tick();

        // Cold miss then hit
        fetch("cold", 32'h0000_0004, 1'b0, 32'h0050_0093, 4);
        fetch("hit", 32'h0000_0004, 1'b1, 32'h0050_0093, 0);
        fetch("hit_n_hold", 32'h0000_0004, 1'b1, 32'h0050_0093, 0);
        check_eq("n_holds", o_if_n, 32'h0050_0093);

        // Conflict on index 1
        fetch("conf_204", 32'h0000_0204, 1'b0, 32'h1111_2222, 2);
        fetch("conf_004", 32'h0000_0004, 1'b0, 32'h0050_0093, 1);
        fetch("conf_004h", 32'h0000_0004, 1'b1, 32'h0050_0093, 0);

        // Cancel mid-miss: line still filled, no if_ok
        i_if_req = 1'b1;
        i_if_a   = 32'h0000_0100;
        tick();
        check_eq("can_req", o_mem_req, 1);
        tick();
        i_cancel = 1'b1;
        i_if_req = 1'b0;
        tick();
        i_cancel = 1'b0;
        check_eq("can_req_held", o_mem_req, 1);
        check_eq("can_a_held", o_mem_a, 32'h0000_0100);
        i_mem_ok = 1'b1;
        i_mem_n  = 32'hDEAD_BEEF;
        tick();
        i_mem_ok = 1'b0;
        check_eq("can_no_ok", o_if_ok, 0);
        check_eq("can_req_drop", o_mem_req, 0);
        check_eq("can_n_unchanged", o_if_n, 32'h0050_0093);
        tick();
        check_eq("can_no_ok2", o_if_ok, 0);
        fetch("can_rehit", 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 0);

        // Flush pulse invalidates
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        fetch("fl_004", 32'h0000_0004, 1'b0, 32'h0050_0093, 1);

        // Flush coinciding with mem_ok: word delivered, line stays invalid
        i_if_req = 1'b1;
        i_if_a   = 32'h0000_0008;
        tick();
        check_eq("flm_req", o_mem_req, 1);
        tick();
        i_mem_ok = 1'b1;
        i_mem_n  = 32'hCAFE_0008;
        i_flush  = 1'b1;
        tick();
        i_mem_ok = 1'b0;
        i_flush  = 1'b0;
        check_eq("flm_ok", o_if_ok, 1);
        check_eq("flm_n", o_if_n, 32'hCAFE_0008);
        i_if_req = 1'b0;
        tick();
        fetch("flm_008", 32'h0000_0008, 1'b0, 32'hCAFE_0008, 1);

        // Flush with a hitting request: served, next one misses
        i_if_req = 1'b1;
        i_if_a   = 32'h0000_0008;
        i_flush  = 1'b1;
        tick();
        i_flush = 1'b0;
        check_eq("flh_ok", o_if_ok, 1);
        check_eq("flh_n", o_if_n, 32'hCAFE_0008);
        check_eq("flh_noreq", o_mem_req, 0);
        i_if_req = 1'b0;
        tick();
        fetch("flh_next", 32'h0000_0008, 1'b0, 32'hCAFE_0008, 1);

        // Asynchronous reset mid-miss
        fetch("pre_rst", 32'h0000_0004, 1'b0, 32'h0050_0093, 1);
        i_if_req = 1'b1;
        i_if_a   = 32'h0000_000C;
        tick();
        check_eq("rm_req", o_mem_req, 1);
        i_if_req = 1'b0;
        #2;
        i_rst = 1'b0;
        #1;
        check_eq("rm_req_async", o_mem_req, 0);
        check_eq("rm_a_async", o_mem_a, 0);
        #2;
        i_rst = 1'b1;
        tick();
        check_eq("rm_idle", o_mem_req, 0);
        fetch("rm_004", 32'h0000_0004, 1'b0, 32'h0050_0093, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
